mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data/address width.
REQ-002 Parameter TIMEOUT, default 15, maximum BUSY cycles waiting for mem_ack before a bus error is flagged; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 MemWriteM  input  1  MEM-stage store request from the EX/MEM pipeline buffer.
REQ-006 MemtoRegM  input  1  MEM-stage load request from the EX/MEM pipeline buffer.
REQ-007 ALUOutM  input  WIDTH  access address.
REQ-008 WriteDataM  input  WIDTH  store data.
REQ-009 mem_req  output  1  registered request to data memory.
REQ-010 mem_we  output  1  registered write enable, valid while mem_req=1.
REQ-011 mem_addr  output  WIDTH  registered address, valid while mem_req=1.
REQ-012 mem_wdata  output  WIDTH  registered store data, valid while mem_req=1.
REQ-013 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-014 mem_rdata  input  WIDTH  load data, valid in the mem_ack cycle.
REQ-015 StallM  output  1  combinational; freezes all pipeline buffers and the PC while high.
REQ-016 ReadDataM  output  WIDTH  registered load result.
REQ-017 BusErr  output  1  registered sticky timeout flag.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-019 Access pending is defined as MemWriteM OR MemtoRegM.
REQ-020 IDLE with access pending SHALL transition to BUSY, registering mem_req=1, mem_we=MemWriteM, mem_addr=ALUOutM and mem_wdata=WriteDataM.
REQ-021 IDLE with no access pending SHALL remain in IDLE with all outputs held.
REQ-022 mem_addr, mem_wdata and mem_we SHALL remain stable throughout BUSY, independent of inputs.
REQ-023 BUSY with mem_ack=1 SHALL transition to DONE and drop mem_req at the same edge.
REQ-024 On that edge, a load (mem_we=0) SHALL load ReadDataM with mem_rdata; a store SHALL leave ReadDataM unchanged.
REQ-025 DONE SHALL unconditionally transition to IDLE after one cycle; StallM=0 in DONE so the pipeline advances exactly once.
REQ-026 StallM SHALL equal (state==IDLE AND access pending) OR state==BUSY.
REQ-027 An access in cycle t with mem_ack in the first BUSY cycle gives StallM high in cycles t and t+1, and StallM low in t+2 (DONE); minimum stall is 2 cycles.
REQ-028 A wait counter SHALL clear on entry to BUSY and increment on each BUSY cycle without mem_ack.
REQ-029 When the counter reaches TIMEOUT with no mem_ack, the block SHALL drop mem_req, set BusErr=1, write ReadDataM=0 for a load, and go to DONE.
REQ-030 mem_ack=1 in the same cycle the counter reaches TIMEOUT SHALL count as success with no error.
REQ-031 BusErr SHALL stay set until rst.
REQ-032 mem_ack while mem_req=0 SHALL be ignored, with no state or output change.
REQ-033 When MemWriteM and MemtoRegM are both 1, the store SHALL take precedence (mem_we=1) and ReadDataM SHALL be unchanged.
REQ-034 Back-to-back accesses SHALL each pass through DONE, so mem_req is low for at least 2 cycles between requests.

Reset
REQ-035 With rst=1 at a posedge, the block SHALL enter IDLE and set mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, BusErr=0 and the counter to 0.
REQ-036 rst SHALL take priority over every transition, including mid-BUSY; the aborted access is not retried.
REQ-037 After rst deasserts, StallM SHALL follow REQ-026 from the first cycle.

Verification
REQ-038 Load: MemtoRegM=1, ALUOutM=0x100, mem_ack after 3 BUSY cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100 and mem_we=0 stable, ReadDataM=0xDEADBEEF, StallM high for 4 cycles then one DONE cycle with StallM low.
REQ-039 Store: MemWriteM=1, ALUOutM=0x40, WriteDataM=0x12345678, mem_ack in the first BUSY cycle -> mem_we=1, mem_wdata=0x12345678, StallM high for 2 cycles, ReadDataM unchanged.
REQ-040 Timeout: TIMEOUT=4, load with no mem_ack -> mem_req drops after 4 BUSY cycles, BusErr=1, ReadDataM=0, BusErr still 1 after a subsequent successful access.
REQ-041 Reset mid-op: rst pulsed in the 2nd BUSY cycle -> next cycle IDLE, mem_req=0, all outputs 0; a late mem_ack is ignored.
REQ-042 Spurious and back-to-back: mem_ack=1 in IDLE -> no change; two consecutive loads -> two distinct requests separated by a DONE cycle, each result captured correctly.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM pipeline stage.
// Turns a load/store request from the EX/MEM buffer into a registered
// request/acknowledge handshake with the data memory. The whole pipeline
// is frozen (StallM) while the access is outstanding. A bounded wait turns
// a missing acknowledge into a sticky bus error.
module mem_access_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15   // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             StallM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             BusErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Eight bits are enough for the largest legal TIMEOUT (255).
    localparam int               CNT_W        = 8;
    // The timeout fires in the BUSY cycle whose increment would reach TIMEOUT.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q,     state_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]   read_data_q, read_data_d;
    logic               bus_err_q,   bus_err_d;
    logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic               access_pending;

    // A store and a load request both count as a pending access.
    assign access_pending = MemWriteM | MemtoRegM;

    // Next-state and next-output logic for the IDLE -> BUSY -> DONE handshake.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        read_data_d = read_data_q;
        bus_err_d   = bus_err_q;
        wait_cnt_d  = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (access_pending) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    // When both requests are set, the store wins.
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = ALUOutM;
                    mem_wdata_d = WriteDataM;
                    wait_cnt_d  = '0;
                end
            end

            BUSY: begin
                // An acknowledge in the timeout cycle still counts as success.
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        read_data_d = mem_rdata;
                    end
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (!mem_we_q) begin
                        read_data_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            DONE: begin
                // One free cycle lets the pipeline advance exactly once.
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; an aborted access is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Stall while a request waits in IDLE or is outstanding; DONE lets the pipeline go.
    assign StallM    = ((state_q == IDLE) && access_pending) || (state_q == BUSY);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ReadDataM = read_data_q;
    assign BusErr    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4). Inputs change 1 time
// unit after each rising edge. Outputs are checked 1 time unit after that.
module tb_mem_access_ctrl;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 4;

    logic             clk;
    logic             rst;
    logic             MemWriteM;
    logic             MemtoRegM;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] WriteDataM;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic             StallM;
    logic [WIDTH-1:0] ReadDataM;
    logic             BusErr;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .BusErr     (BusErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Moves to the next cycle: the edge, then 1 time unit for the inputs to be driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Lets combinational outputs settle after the inputs change.
    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic we, input logic rd,
                           input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
        MemWriteM  = we;
        MemtoRegM  = rd;
        ALUOutM    = addr;
        WriteDataM = wdata;
    endtask

    initial begin
        rst        = 1'b1;
        set_req(1'b0, 1'b0, '0, '0);
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();

        // Reset state
        check("rst_req",   32'(mem_req),   32'd0);
        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_addr",  mem_addr,       32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_rdata", ReadDataM,      32'd0);
        check("rst_err",   32'(BusErr),    32'd0);
        check("rst_stall", 32'(StallM),    32'd0);

        // A spurious acknowledge in IDLE changes nothing
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        next_cycle();
        check("spur_req",   32'(mem_req), 32'd0);
        check("spur_rdata", ReadDataM,    32'd0);
        check("spur_stall", 32'(StallM),  32'd0);
        mem_ack = 1'b0;

        // Load at 0x100 with the acknowledge in the 3rd BUSY cycle
        set_req(1'b0, 1'b1, 32'h100, 32'h0000_AAAA);
        settle();
        check("ld_stall_idle", 32'(StallM), 32'd1);
        next_cycle();                                   // BUSY 1
        ALUOutM = 32'h999; WriteDataM = 32'h5A5A_5A5A;  // must not disturb the held request
        settle();
        check("ld_b1_req",   32'(mem_req), 32'd1);
        check("ld_b1_addr",  mem_addr,     32'h100);
        check("ld_b1_we",    32'(mem_we),  32'd0);
        check("ld_b1_stall", 32'(StallM),  32'd1);
        next_cycle();                                   // BUSY 2
        check("ld_b2_addr",  mem_addr,     32'h100);
        check("ld_b2_stall", 32'(StallM),  32'd1);
        next_cycle();                                   // BUSY 3
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("ld_b3_addr",  mem_addr,     32'h100);
        check("ld_b3_we",    32'(mem_we),  32'd0);
        check("ld_b3_stall", 32'(StallM),  32'd1);
        next_cycle();                                   // DONE
        mem_ack = 1'b0;
        settle();
        check("ld_done_req",   32'(mem_req), 32'd0);
        check("ld_done_rdata", ReadDataM,    32'hDEAD_BEEF);
        check("ld_done_stall", 32'(StallM),  32'd0);
        check("ld_done_err",   32'(BusErr),  32'd0);
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();                                   // IDLE
        check("ld_idle_stall", 32'(StallM), 32'd0);

        // Store at 0x40 with the acknowledge in the 1st BUSY cycle
        set_req(1'b1, 1'b0, 32'h40, 32'h1234_5678);
        settle();
        check("st_stall_idle", 32'(StallM), 32'd1);
        next_cycle();                                   // BUSY 1
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        settle();
        check("st_b1_req",   32'(mem_req), 32'd1);
        check("st_b1_we",    32'(mem_we),  32'd1);
        check("st_b1_addr",  mem_addr,     32'h40);
        check("st_b1_wdata", mem_wdata,    32'h1234_5678);
        check("st_b1_stall", 32'(StallM),  32'd1);
        next_cycle();                                   // DONE
        mem_ack = 1'b0;
        settle();
        check("st_done_req",   32'(mem_req), 32'd0);
        check("st_done_stall", 32'(StallM),  32'd0);
        check("st_done_rdata", ReadDataM,    32'hDEAD_BEEF);
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();

        // Store and load both requested: the store wins, ReadDataM is untouched
        set_req(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D);
        next_cycle();                                   // BUSY 1
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        settle();
        check("both_we",    32'(mem_we), 32'd1);
        check("both_wdata", mem_wdata,   32'hCAFE_F00D);
        next_cycle();                                   // DONE
        mem_ack = 1'b0;
        settle();
        check("both_rdata", ReadDataM, 32'hDEAD_BEEF);
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();

        // Acknowledge in the last allowed BUSY cycle counts as success
        set_req(1'b0, 1'b1, 32'h200, '0);
        next_cycle();                                   // BUSY 1
        next_cycle();                                   // BUSY 2
        next_cycle();                                   // BUSY 3
        next_cycle();                                   // BUSY 4
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        settle();
        check("edge_b4_req", 32'(mem_req), 32'd1);
        next_cycle();                                   // DONE
        mem_ack = 1'b0;
        settle();
        check("edge_err",   32'(BusErr),  32'd0);
        check("edge_rdata", ReadDataM,    32'h0BAD_CAFE);
        check("edge_req",   32'(mem_req), 32'd0);
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();

        // Load with no acknowledge times out after 4 BUSY cycles
        set_req(1'b0, 1'b1, 32'h300, '0);
        next_cycle();                                   // BUSY 1
        next_cycle();                                   // BUSY 2
        next_cycle();                                   // BUSY 3
        next_cycle();                                   // BUSY 4
        check("to_b4_req",   32'(mem_req), 32'd1);
        check("to_b4_err",   32'(BusErr),  32'd0);
        check("to_b4_stall", 32'(StallM),  32'd1);
        next_cycle();                                   // DONE
        check("to_done_req",   32'(mem_req), 32'd0);
        check("to_done_err",   32'(BusErr),  32'd1);
        check("to_done_rdata", ReadDataM,    32'd0);
        check("to_done_stall", 32'(StallM),  32'd0);
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();
        // A later successful load leaves the error flag set
        set_req(1'b0, 1'b1, 32'h304, '0);
        next_cycle();                                   // BUSY 1
        mem_ack = 1'b1; mem_rdata = 32'h600D_F00D;
        next_cycle();                                   // DONE
        mem_ack = 1'b0;
        settle();
        check("to_after_rdata", ReadDataM,   32'h600D_F00D);
        check("to_after_err",   32'(BusErr), 32'd1);
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();

        // Two back-to-back loads, each passing through DONE
        set_req(1'b0, 1'b1, 32'h10, '0);
        next_cycle();                                   // BUSY 1 (A)
        check("b2b_a_addr", mem_addr, 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'hA1A1_A1A1;
        next_cycle();                                   // DONE (A)
        mem_ack = 1'b0;
        settle();
        check("b2b_a_req",   32'(mem_req), 32'd0);
        check("b2b_a_rdata", ReadDataM,    32'hA1A1_A1A1);
        check("b2b_a_stall", 32'(StallM),  32'd0);
        next_cycle();                                   // IDLE, next load presented
        ALUOutM = 32'h14;
        settle();
        check("b2b_gap_req",   32'(mem_req), 32'd0);
        check("b2b_gap_stall", 32'(StallM),  32'd1);
        next_cycle();                                   // BUSY 1 (B)
        check("b2b_b_req",  32'(mem_req), 32'd1);
        check("b2b_b_addr", mem_addr,     32'h14);
        mem_ack = 1'b1; mem_rdata = 32'hB2B2_B2B2;
        next_cycle();                                   // DONE (B)
        mem_ack = 1'b0;
        settle();
        check("b2b_b_rdata", ReadDataM, 32'hB2B2_B2B2);
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();

        // Reset in the 2nd BUSY cycle aborts the access; a late acknowledge is ignored
        set_req(1'b0, 1'b1, 32'h500, '0);
        next_cycle();                                   // BUSY 1
        next_cycle();                                   // BUSY 2
        rst = 1'b1;
        set_req(1'b0, 1'b0, '0, '0);
        next_cycle();                                   // reset applied
        rst = 1'b0;
        settle();
        check("mid_rst_req",   32'(mem_req), 32'd0);
        check("mid_rst_we",    32'(mem_we),  32'd0);
        check("mid_rst_addr",  mem_addr,     32'd0);
        check("mid_rst_wdata", mem_wdata,    32'd0);
        check("mid_rst_rdata", ReadDataM,    32'd0);
        check("mid_rst_err",   32'(BusErr),  32'd0);
        check("mid_rst_stall", 32'(StallM),  32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        next_cycle();
        check("late_ack_req",   32'(mem_req), 32'd0);
        check("late_ack_rdata", ReadDataM,    32'd0);
        check("late_ack_stall", 32'(StallM),  32'd0);
        mem_ack = 1'b0;
        next_cycle();
        check("late_ack_idle_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
